// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding (IEEE 1149.1 values), opcodes and IR decode helpers.
package jtag_pkg;

  localparam int IR_W = 4;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t ST_EX2DR = 4'h0;
  localparam tap_state_t ST_EX1DR = 4'h1;
  localparam tap_state_t ST_SHDR  = 4'h2;
  localparam tap_state_t ST_PAUDR = 4'h3;
  localparam tap_state_t ST_SELIR = 4'h4;
  localparam tap_state_t ST_UPDDR = 4'h5;
  localparam tap_state_t ST_CAPDR = 4'h6;
  localparam tap_state_t ST_SELDR = 4'h7;
  localparam tap_state_t ST_EX2IR = 4'h8;
  localparam tap_state_t ST_EX1IR = 4'h9;
  localparam tap_state_t ST_SHIR  = 4'hA;
  localparam tap_state_t ST_PAUIR = 4'hB;
  localparam tap_state_t ST_RTI   = 4'hC;
  localparam tap_state_t ST_UPDIR = 4'hD;
  localparam tap_state_t ST_CAPIR = 4'hE;
  localparam tap_state_t ST_TLR   = 4'hF;

  localparam logic [IR_W-1:0] OP_IDCODE  = 4'h1;
  localparam logic [IR_W-1:0] OP_USER    = 4'h8;
  localparam logic [IR_W-1:0] OP_BYPASS  = 4'hF;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_t;

  // Unknown opcodes fall back to BYPASS.
  function automatic dr_sel_t decode_ir(input logic [IR_W-1:0] op);
    case (op)
      OP_IDCODE: decode_ir = DR_IDCODE;
      OP_USER:   decode_ir = DR_USER;
      OP_BYPASS: decode_ir = DR_BYPASS;
      default:   decode_ir = DR_BYPASS;
    endcase
  endfunction

  function automatic logic is_ir_path(input tap_state_t s);
    is_ir_path = (s inside {ST_CAPIR, ST_SHIR, ST_EX1IR, ST_PAUIR, ST_EX2IR, ST_UPDIR});
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Combinational next-state logic of the 16-state TAP controller, advanced on sampled tms.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  tap_state_t state_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  always_comb begin
    state_o = ST_TLR;
    case (state_i)
      ST_TLR:   state_o = tms_i ? ST_TLR   : ST_RTI;
      ST_RTI:   state_o = tms_i ? ST_SELDR : ST_RTI;
      ST_SELDR: state_o = tms_i ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_o = tms_i ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_o = tms_i ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_o = tms_i ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: state_o = tms_i ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: state_o = tms_i ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: state_o = tms_i ? ST_SELDR : ST_RTI;
      ST_SELIR: state_o = tms_i ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_o = tms_i ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_o = tms_i ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_o = tms_i ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: state_o = tms_i ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: state_o = tms_i ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: state_o = tms_i ? ST_SELDR : ST_RTI;
      default:  state_o = ST_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP oversampled by clk, with IDCODE, USER and BYPASS data registers.
// Define JTAG_TAP_SYNC_EN to add 2-flop synchronizers on tck/tms/tdi (3 clk pin-to-action).
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          DEFAULT    = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tck,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_oe,
  output logic [3:0]         tap_state,
  output logic [IR_W-1:0]    ir,
  input  logic [DEFAULT-1:0] user_in,
  output logic [DEFAULT-1:0] user_out,
  output logic               user_upd
);

  logic tck_s, tms_s, tdi_s;

`ifdef JTAG_TAP_SYNC_EN
  logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sync_q <= 2'b00;
      tms_sync_q <= 2'b00;
      tdi_sync_q <= 2'b00;
    end else begin
      tck_sync_q <= {tck_sync_q[0], tck};
      tms_sync_q <= {tms_sync_q[0], tms};
      tdi_sync_q <= {tdi_sync_q[0], tdi};
    end
  end

  assign tck_s = tck_sync_q[1];
  assign tms_s = tms_sync_q[1];
  assign tdi_s = tdi_sync_q[1];
`else
  assign tck_s = tck;
  assign tms_s = tms;
  assign tdi_s = tdi;
`endif

  // A single history bit means rise and fall are mutually exclusive per clk.
  logic tck_hist_q;
  logic rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tck_hist_q <= 1'b0;
    else     tck_hist_q <= tck_s;
  end

  assign rise = tck_s & ~tck_hist_q;
  assign fall = ~tck_s & tck_hist_q;

  tap_state_t state_q, state_d;

  jtag_tap_fsm u_fsm (
    .state_i (state_q),
    .tms_i   (tms_s),
    .state_o (state_d)
  );

  logic [IR_W-1:0]    ir_q, ir_sr_q;
  logic [31:0]        id_sr_q;
  logic [DEFAULT-1:0] user_sr_q, user_out_q;
  logic               byp_q, tdo_q, user_upd_q;
  dr_sel_t            dr_sel;
  logic               sel_lsb;

  assign dr_sel = decode_ir(ir_q);

  always_comb begin
    sel_lsb = byp_q;
    if (is_ir_path(state_q))     sel_lsb = ir_sr_q[0];
    else if (dr_sel == DR_IDCODE) sel_lsb = id_sr_q[0];
    else if (dr_sel == DR_USER)   sel_lsb = user_sr_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_TLR;
      ir_q       <= OP_IDCODE;
      ir_sr_q    <= '0;
      id_sr_q    <= '0;
      user_sr_q  <= '0;
      byp_q      <= 1'b0;
      tdo_q      <= 1'b0;
      user_out_q <= '0;
      user_upd_q <= 1'b0;
    end else begin
      user_upd_q <= 1'b0;
      if (rise) begin
        state_q <= state_d;
        case (state_q)
          ST_CAPIR: ir_sr_q <= IR_CAPTURE;
          ST_SHIR:  ir_sr_q <= {tdi_s, ir_sr_q[IR_W-1:1]};
          ST_CAPDR: begin
            case (dr_sel)
              DR_IDCODE: id_sr_q   <= IDCODE_VAL;
              DR_USER:   user_sr_q <= user_in;
              default:   byp_q     <= 1'b0;
            endcase
          end
          ST_SHDR: begin
            case (dr_sel)
              DR_IDCODE: id_sr_q   <= {tdi_s, id_sr_q[31:1]};
              DR_USER:   user_sr_q <= {tdi_s, user_sr_q[DEFAULT-1:1]};
              default:   byp_q     <= tdi_s;
            endcase
          end
          default: ;
        endcase
        // Update actions fire on entry; the shift registers are stable in Exit/Pause states.
        if (state_d == ST_TLR) begin
          ir_q <= OP_IDCODE;
        end else if (state_d == ST_UPDIR) begin
          ir_q <= ir_sr_q;
        end else if (state_d == ST_UPDDR && dr_sel == DR_USER) begin
          user_out_q <= user_sr_q;
          user_upd_q <= 1'b1;
        end
      end else if (fall) begin
        tdo_q <= sel_lsb;
      end
    end
  end

  assign tdo       = tdo_q;
  assign tdo_oe    = (state_q == ST_SHIR) || (state_q == ST_SHDR);
  assign tap_state = state_q;
  assign ir        = ir_q;
  assign user_out  = user_out_q;
  assign user_upd  = user_upd_q;

endmodule
